fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Parametrised instruction/operand fetch engine sitting between the PC/memory bus and execute.
//  Fetches the opcode, then fetches operand bytes and pointers as the decoded addressing mode requires.
//  Produces the effective address (EA), immediate and page-cross flag, presented on a valid/ack handshake.
//  Adds over the earlier fetcher:
//   - bus req/ack wait states
//   - full indirect modes
//   - selectable zero-page wrap
//   - PC redirect/abort
//   - back-to-back fetch
// PARAMETERS
//  ADDR_WIDTH  16       address bus / PC / EA width (>=16)
//  REG_WIDTH   8        data bus and index register width
//  RESET_PC    16'h8000 PC value loaded on reset
//  ZP_WRAP     1        1: zero-page index/pointer arithmetic wraps in page 0; 0: carry propagates to bit 8
// PORTS
//  phi1          in   1           single clock, all state on rising edge
//  reset_n       in   1           asynchronous active-low reset
//  get_next      in   1           start fetch at current PC (sampled in IDLE or DONE only)
//  pc_load       in   1           redirect: abort any sequence, PC <= pc_load_val
//  pc_load_val   in   ADDR_WIDTH  redirect target
//  x_reg, y_reg  in   REG_WIDTH   index registers, sampled in the cycle of use
//  mem_req       out  1           bus read request
//  mem_addr      out  ADDR_WIDTH  read address, stable while mem_req high
//  mem_ack       in   1           read complete; mem_data valid this cycle
//  mem_data      in   REG_WIDTH   read data
//  pc            out  ADDR_WIDTH  PC: address of the next unfetched byte
//  opcode        out  REG_WIDTH   latched opcode
//  mode          out  3           addressing mode; opcode[4:2] for group 1 (opcode[1:0]==2'b01), else 3'b111 with implied=1
//  implied       out  1           opcode has no operand
//  ea            out  ADDR_WIDTH  effective address (imm mode: address of the operand byte)
//  imm           out  REG_WIDTH   immediate operand (imm mode only, else 0)
//  page_cross    out  1           abs,X / abs,Y / (zp),Y: low-byte add carried
//  instr_valid   out  1           outputs valid; held until instr_ack
//  instr_ack     in   1           execute consumed the instruction
// BEHAVIOUR
//  Reset: state IDLE, pc = RESET_PC; all other outputs 0.
//  States: IDLE, OPC, OP_LO, OP_HI, PTR_LO, PTR_HI, DONE.
//  Each non-IDLE/DONE state issues one read (mem_req=1).
//  The state advances only on the edge that samples mem_ack=1; mem_addr/mem_req hold otherwise.
//  Operand reads (OPC/OP_LO/OP_HI) use mem_addr=pc and increment pc on ack, mod 2^ADDR_WIDTH.
//  Group-1 mode sequences (d0 = first operand byte, d1 = second, lo/hi = pointer reads):
//   000 (zp,X): OPC,OP_LO,PTR_LO@p,PTR_HI@p+1; p=d0+X; ea={hi,lo}
//   001 zp: OPC,OP_LO; ea={0,d0}
//   010 imm: OPC,OP_LO; imm=d0, ea=operand address
//   011 abs: OPC,OP_LO,OP_HI; ea={d1,d0}
//   100 (zp),Y: OPC,OP_LO,PTR_LO@d0,PTR_HI@d0+1; ea={hi,lo}+Y
//   101 zp,X: OPC,OP_LO; ea=d0+X
//   110 abs,Y: OPC,OP_LO,OP_HI; ea={d1,d0}+Y
//   111 abs,X: OPC,OP_LO,OP_HI; ea={d1,d0}+X
//  Non-group-1 opcodes: OPC only; implied=1; ea=0.
//  Zero-page sums (p, p+1, d0+X):
//   ZP_WRAP=1: truncated to 8 bits, upper bits 0
//   ZP_WRAP=0: 9-bit sum, zero-extended
//  Indexed 16-bit adds are mod 2^ADDR_WIDTH; page_cross = carry out of bit 7 of the low-byte add.
//  Latency: with k reads and mem_ack tied high, get_next sampled at edge t gives instr_valid=1 after edge t+k.
//  DONE: instr_valid=1; ea/imm/opcode/mode/page_cross frozen until instr_ack.
//  On the ack edge:
//   - get_next=1: go to OPC (no bubble)
//   - get_next=0: go to IDLE
//  instr_valid drops after the ack edge.
//  get_next outside IDLE/DONE is ignored.
//  pc_load (highest priority, any state):
//   - next state IDLE, pc=pc_load_val, mem_req=0, instr_valid=0
//   - a simultaneous mem_ack or get_next is ignored
//  reset_n low mid-sequence: immediate return to reset values; no partial results retained.
// TESTING
//  ack=1, PC=8000, mem[8000..]=A9? No. Use mem[8000]=69,mem[8001]=42 (imm), get_next -> valid after 2 edges, imm=42, ea=8001, pc=8002.
//  mem 8000=7D,01=F0,02=12, X=20, abs,X -> ea=1310, page_cross=1, pc=8003, valid after 3 edges.
//  (zp),Y: mem 8000=71,01=FF, 00FF=34, 0000=12 (ZP_WRAP=1), Y=01 -> ea=1235; ZP_WRAP=0 pointer hi read @0100.
//  mem_ack low 3 cycles on each read of zp -> mem_addr/mem_req held stable, valid after 2+6 edges, ea correct.
//  pc_load=9000 asserted mid-OP_HI with mem_ack=1 same edge -> IDLE, pc=9000, mem_req=0, no instr_valid.
//  Back-to-back: instr_ack & get_next same edge -> OPC next cycle at pc, no IDLE cycle; reset_n low mid-PTR_LO -> all outputs 0, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction/operand fetch engine between the PC/memory bus and execute.
//   It reads the opcode, then the operand bytes and zero-page pointers that the
//   decoded addressing mode needs. It then presents the effective address,
//   the immediate and the page-cross flag on a valid/ack handshake.
//
// Ports
//   phi1, reset_n           clock (rising edge), async active-low reset
//   get_next                start a fetch at pc (acted on in IDLE, or DONE with instr_ack)
//   pc_load, pc_load_val    redirect: abort any sequence and load pc
//   x_reg, y_reg            index registers
//   mem_req/mem_addr        bus read request and address
//   mem_ack/mem_data        read completion and read data
//   pc                      address of the next unfetched byte
//   opcode, mode, implied   latched opcode and its decode
//   ea, imm, page_cross     fetch results
//   instr_valid/instr_ack   result handshake
//
// state  | meaning
// IDLE   | no fetch in progress
// OPC    | reading opcode at pc
// OP_LO  | reading first operand byte at pc
// OP_HI  | reading second operand byte at pc
// PTR_LO | reading pointer low byte from zero page
// PTR_HI | reading pointer high byte from zero page
// DONE   | results valid, waiting for instr_ack

module fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    REG_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h8000,
  parameter bit                    ZP_WRAP    = 1'b1
) (
  input  logic                  phi1,
  input  logic                  reset_n,
  input  logic                  get_next,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_val,
  input  logic [REG_WIDTH-1:0]  x_reg,
  input  logic [REG_WIDTH-1:0]  y_reg,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [REG_WIDTH-1:0]  mem_data,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [REG_WIDTH-1:0]  opcode,
  output logic [2:0]            mode,
  output logic                  implied,
  output logic [ADDR_WIDTH-1:0] ea,
  output logic [REG_WIDTH-1:0]  imm,
  output logic                  page_cross,
  output logic                  instr_valid,
  input  logic                  instr_ack
);

  localparam int ZW = REG_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_OP_LO, S_OP_HI, S_PTR_LO, S_PTR_HI, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [REG_WIDTH-1:0]  d0;
  logic [REG_WIDTH-1:0]  ptr_lo;
  logic [ZW-1:0]         ptr_addr;
  logic [ZW-1:0]         ptr_inc;
  logic [ZW-1:0]         ptr_hi_addr;
  logic [REG_WIDTH-1:0]  idx;
  logic [REG_WIDTH-1:0]  lo_byte;
  logic [ZW-1:0]         lo_sum;
  logic [ADDR_WIDTH-1:0] ea_idx;

  // Zero-page sum: with wrapping the carry into bit 8 is dropped.
  function automatic logic [ZW-1:0] zp_add(input logic [REG_WIDTH-1:0] a,
                                           input logic [REG_WIDTH-1:0] b);
    logic [ZW-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (ZP_WRAP) s[REG_WIDTH] = 1'b0;
    return s;
  endfunction

  // A non-wrapping pointer never exceeds 0x1FE, so p+1 still fits in ZW bits.
  assign ptr_inc     = ptr_addr + ZW'(1);
  assign ptr_hi_addr = ZP_WRAP ? {1'b0, ptr_inc[REG_WIDTH-1:0]} : ptr_inc;

  // Shared indexed add for abs,X / abs,Y (in OP_HI) and (zp),Y (in PTR_HI).
  always_comb begin
    idx = '0;
    if (mode == 3'b110 || mode == 3'b100) idx = y_reg;
    else if (mode == 3'b111)              idx = x_reg;
  end

  assign lo_byte = (state == S_OP_HI) ? d0 : ptr_lo;
  assign lo_sum  = {1'b0, lo_byte} + {1'b0, idx};
  assign ea_idx  = ADDR_WIDTH'({mem_data, lo_byte}) + ADDR_WIDTH'(idx);

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    mem_addr    = '0;
    instr_valid = 1'b0;
    case (state)
      S_OPC, S_OP_LO, S_OP_HI: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      S_PTR_LO: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_WIDTH'(ptr_addr);
      end
      S_PTR_HI: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_WIDTH'(ptr_hi_addr);
      end
      S_DONE:  instr_valid = 1'b1;
      default: ;
    endcase

    if (pc_load) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (get_next) state_nxt = S_OPC;
        S_OPC:    if (mem_ack) state_nxt = (mem_data[1:0] == 2'b01) ? S_OP_LO : S_DONE;
        S_OP_LO:  if (mem_ack) begin
          case (mode)
            3'b000, 3'b100:         state_nxt = S_PTR_LO;
            3'b011, 3'b110, 3'b111: state_nxt = S_OP_HI;
            default:                state_nxt = S_DONE;
          endcase
        end
        S_OP_HI:  if (mem_ack) state_nxt = S_DONE;
        S_PTR_LO: if (mem_ack) state_nxt = S_PTR_HI;
        S_PTR_HI: if (mem_ack) state_nxt = S_DONE;
        S_DONE:   if (instr_ack) state_nxt = get_next ? S_OPC : S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      opcode     <= '0;
      mode       <= '0;
      implied    <= 1'b0;
      ea         <= '0;
      imm        <= '0;
      page_cross <= 1'b0;
      d0         <= '0;
      ptr_lo     <= '0;
      ptr_addr   <= '0;
    end else if (pc_load) begin
      pc <= pc_load_val;
    end else if (mem_ack) begin
      case (state)
        S_OPC: begin
          opcode <= mem_data;
          pc     <= pc + ADDR_WIDTH'(1);
          if (mem_data[1:0] == 2'b01) begin
            mode    <= mem_data[4:2];
            implied <= 1'b0;
          end else begin
            mode       <= 3'b111;
            implied    <= 1'b1;
            ea         <= '0;
            imm        <= '0;
            page_cross <= 1'b0;
          end
        end
        S_OP_LO: begin
          d0       <= mem_data;
          pc       <= pc + ADDR_WIDTH'(1);
          ptr_addr <= (mode == 3'b000) ? zp_add(mem_data, x_reg) : {1'b0, mem_data};
          case (mode)
            3'b001: begin
              ea         <= ADDR_WIDTH'(mem_data);
              imm        <= '0;
              page_cross <= 1'b0;
            end
            3'b010: begin
              ea         <= pc;
              imm        <= mem_data;
              page_cross <= 1'b0;
            end
            3'b101: begin
              ea         <= ADDR_WIDTH'(zp_add(mem_data, x_reg));
              imm        <= '0;
              page_cross <= 1'b0;
            end
            default: ;
          endcase
        end
        S_OP_HI: begin
          pc         <= pc + ADDR_WIDTH'(1);
          ea         <= ea_idx;
          imm        <= '0;
          page_cross <= lo_sum[REG_WIDTH];
        end
        S_PTR_LO: ptr_lo <= mem_data;
        S_PTR_HI: begin
          ea         <= ea_idx;
          imm        <= '0;
          page_cross <= lo_sum[REG_WIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule
